// File: rtl/fib_seq_engine.sv
// fib_seq_engine: iterative Fibonacci/Lucas term generator with start/done handshake,
// exact overflow tracking of the requested term and optional saturation.
module fib_seq_engine #(
    parameter int WIDTH    = 32,
    parameter int N_WIDTH  = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [N_WIDTH-1:0] i_n,
    input  logic               i_mode,
    output logic               o_busy,
    output logic               o_done,
    output logic [WIDTH-1:0]   o_fib,
    output logic               o_overflow
);
    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t             r_state, w_next;
    logic [N_WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a, r_b;
    logic               r_a_ovf, r_b_ovf;
    logic [WIDTH:0]     w_sum;
    logic               w_load, w_step, w_fin;
    assign w_sum = {1'b0, r_a} + {1'b0, r_b};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state == S_IDLE ? (i_start ? S_RUN : S_IDLE) : (r_cnt == '0 ? S_IDLE : S_RUN);
    end
    always_comb begin
        o_busy = r_state == S_RUN;
        w_load = r_state == S_IDLE && i_start;
        w_step = r_state == S_RUN && r_cnt != '0;
        w_fin  = r_state == S_RUN && r_cnt == '0;
    end
    // r_b runs one term ahead of r_a; only r_a's overflow flag reaches the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_a_ovf    <= 1'b0;
            r_b_ovf    <= 1'b0;
            o_done     <= 1'b0;
            o_fib      <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_done <= w_fin;
            if (w_load) begin
                r_cnt   <= i_n;
                r_a     <= i_mode ? WIDTH'(2) : '0;
                r_b     <= WIDTH'(1);
                r_a_ovf <= 1'b0;
                r_b_ovf <= 1'b0;
            end else if (w_step) begin
                r_cnt   <= r_cnt - 1'b1;
                r_a     <= r_b;
                r_a_ovf <= r_b_ovf;
                r_b     <= w_sum[WIDTH-1:0];
                r_b_ovf <= r_a_ovf | r_b_ovf | w_sum[WIDTH];
            end
            if (w_fin) begin
                o_fib      <= (SATURATE && r_a_ovf) ? '1 : r_a;
                o_overflow <= r_a_ovf;
            end
        end
    end
endmodule

// File: tb/tb_fib_seq_engine.sv
// tb_fib_seq_engine: four configurations (32/8 bit, wrap/saturate) driven by shared
// stimulus and compared against an exact 64-bit sequence model.
module tb_fib_seq_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_start = 1'b0;
    logic [7:0]  i_n = '0;
    logic        i_mode = 1'b0;
    logic        busy32, done32, ovf32, busy32s, done32s, ovf32s;
    logic        busy8, done8, ovf8, busy8s, done8s, ovf8s;
    logic [31:0] fib32, fib32s;
    logic [7:0]  fib8, fib8s;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    fib_seq_engine #(.WIDTH(32), .N_WIDTH(8), .SATURATE(0)) u_d32 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_n(i_n), .i_mode(i_mode),
        .o_busy(busy32), .o_done(done32), .o_fib(fib32), .o_overflow(ovf32));
    fib_seq_engine #(.WIDTH(32), .N_WIDTH(8), .SATURATE(1)) u_d32s (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_n(i_n), .i_mode(i_mode),
        .o_busy(busy32s), .o_done(done32s), .o_fib(fib32s), .o_overflow(ovf32s));
    fib_seq_engine #(.WIDTH(8), .N_WIDTH(8), .SATURATE(0)) u_d8 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_n(i_n), .i_mode(i_mode),
        .o_busy(busy8), .o_done(done8), .o_fib(fib8), .o_overflow(ovf8));
    fib_seq_engine #(.WIDTH(8), .N_WIDTH(8), .SATURATE(1)) u_d8s (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_n(i_n), .i_mode(i_mode),
        .o_busy(busy8s), .o_done(done8s), .o_fib(fib8s), .o_overflow(ovf8s));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // exact term of the sequence; fits 64 bits for n <= 90
    function automatic longint unsigned ref_term(input int nn, input bit md);
        longint unsigned t[0:90];
        t[0] = md ? 64'd2 : 64'd0;
        t[1] = 64'd1;
        for (int i = 2; i <= nn; i++) t[i] = t[i-1] + t[i-2];
        return t[nn];
    endfunction

    function automatic bit ref_ovf(input longint unsigned tv, input int w);
        return (tv >> w) != 0;
    endfunction

    function automatic longint unsigned ref_fib(input longint unsigned tv, input int w, input bit sat);
        longint unsigned m = (64'd1 << w) - 1;
        return (sat && ref_ovf(tv, w)) ? m : (tv & m);
    endfunction

    task automatic req(input int nn, input bit md, input int glitch);
        int              cyc = 0;
        bit              bad_busy = 0, bad_hold = 0;
        logic [31:0]     held = fib32;
        longint unsigned tv = ref_term(nn, md);
        i_start = 1'b1;
        i_n     = 8'(nn);
        i_mode  = md;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_n     = 8'($urandom);
        i_mode  = 1'($urandom);
        chk("busy_accept", busy32, 1);
        while (!done32 && cyc < nn + 8) begin
            if (cyc == glitch) begin
                i_start = 1'b1;
                i_n     = 8'd5;
            end else i_start = 1'b0;
            @(posedge clk); #1;
            cyc++;
            i_n    = 8'($urandom);
            i_mode = 1'($urandom);
            if (!done32 && !busy32) bad_busy = 1;
            if (!done32 && fib32 !== held) bad_hold = 1;
        end
        i_start = 1'b0;
        chk("latency", cyc, nn + 1);
        chk("busy_run", bad_busy, 0);
        chk("fib_hold", bad_hold, 0);
        chk("busy_done", busy32, 0);
        chk("done_all", {done32s, done8, done8s}, 3'b111);
        chk("fib32", fib32, ref_fib(tv, 32, 0));
        chk("ovf32", ovf32, ref_ovf(tv, 32));
        chk("fib32s", fib32s, ref_fib(tv, 32, 1));
        chk("ovf32s", ovf32s, ref_ovf(tv, 32));
        chk("fib8", fib8, ref_fib(tv, 8, 0));
        chk("ovf8", ovf8, ref_ovf(tv, 8));
        chk("fib8s", fib8s, ref_fib(tv, 8, 1));
        chk("ovf8s", ovf8s, ref_ovf(tv, 8));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy32, 0);
        chk("rst_done", done32, 0);
        chk("rst_fib", fib32, 0);
        chk("rst_ovf", ovf32, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= 48; k++) req(k, 0, -1);
        req(13, 0, -1);
        req(14, 0, -1);
        req(0, 1, -1);
        req(1, 1, -1);
        req(10, 1, -1);
        req(10, 0, -1);
        req(20, 0, 3);
        @(posedge clk); #1;
        chk("single_done", done32, 0);
        i_start = 1'b1;
        i_n     = 8'd30;
        i_mode  = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy32, 0);
        chk("abort_done", done32, 0);
        chk("abort_fib", fib32, 0);
        chk("abort_ovf", ovf32, 0);
        @(posedge clk); #1;
        chk("abort_nodone", done32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req(3, 0, -1);
        for (int r = 0; r < 40; r++) begin
            int nn  = int'($urandom_range(0, 90));
            int gap = int'($urandom_range(0, 2));
            req(nn, 1'($urandom), nn > 2 ? int'($urandom_range(0, nn - 1)) : -1);
            repeat (gap) begin
                @(posedge clk); #1;
                chk("done_pulse", done32, 0);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
